// File: rtl/mem_bus_pkg.sv
// Shared encodings for the unified memory bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2
  } arb_state_t;

  // Fetches always read a full word.
  localparam logic [3:0]  BE_WORD       = 4'hF;

  // Read data returned to a port whose access was aborted by the watchdog.
  localparam logic [31:0] BUS_ERR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/mem_watchdog.sv
// Bus watchdog: counts cycles spent waiting for an ack and flags expiry.
// Latency: expired is combinational, high in the TIMEOUT-th enabled cycle without clr.
// Backpressure: none; the counter restarts whenever clr, expiry or !en.
module mem_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expired
);

  // cnt holds the number of completed waiting cycles, so the cycle in which
  // it equals TIMEOUT-1 is the TIMEOUT-th cycle spent without an ack.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  assign expired = en & ~clr & (cnt == LAST);

  // Count while enabled; restart on ack, on expiry and while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || expired || !en) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported memory bus between fetch (I) and load/store (D), D first.
// Latency: request in cycle N -> mem_req in N+1; ack in N+1+k -> arb_stall low in N+2+k.
// Backpressure: arb_stall freezes the pipeline until every pending port access is done.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_stall,
  output logic              bus_err
);

  localparam logic [DATA_W-1:0] ERR_RDATA = DATA_W'(BUS_ERR_RDATA);

  arb_state_t state, state_nxt;

  logic i_done, d_done;
  logic i_pend, d_pend;
  logic busy, ack_ok, timeout, fin;
  logic issue_d, issue_i;

  // A port is pending while it requests and its current access is not yet done.
  assign i_pend    = i_req & ~i_done;
  assign d_pend    = d_req & ~d_done;
  assign arb_stall = i_pend | d_pend;

  assign busy    = (state != IDLE);
  assign ack_ok  = busy & mem_ack;   // acks outside a transaction are ignored
  assign fin     = ack_ok | timeout;
  assign bus_err = timeout;

  mem_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .en      (busy),
    .clr     (ack_ok),
    .expired (timeout)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and issue decisions; after an ack the other port is issued
  // back-to-back, after a timeout the bus always returns to IDLE first.
  always_comb begin
    state_nxt = state;
    issue_d   = 1'b0;
    issue_i   = 1'b0;
    case (state)
      IDLE: begin
        if (d_pend) begin
          state_nxt = BUSY_D;
          issue_d   = 1'b1;
        end else if (i_pend) begin
          state_nxt = BUSY_I;
          issue_i   = 1'b1;
        end
      end
      BUSY_D: begin
        if (fin) begin
          if (ack_ok && i_pend) begin
            state_nxt = BUSY_I;
            issue_i   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      BUSY_I: begin
        if (fin) begin
          if (ack_ok && d_pend) begin
            state_nxt = BUSY_D;
            issue_d   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus request registers: sampled only at issue, held until the access ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (issue_d) begin
      mem_req   <= 1'b1;
      mem_we    <= d_we;
      mem_be    <= d_be;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
    end else if (issue_i) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_be    <= BE_WORD;
      mem_addr  <= i_addr;
      mem_wdata <= '0;
    end else if (fin) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  // Done flags: set on completion, dropped when the pipeline advances.
  // Completion wins so a flushed access still reports done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      if (fin && state == BUSY_I) begin
        i_done <= 1'b1;
      end else if (!arb_stall) begin
        i_done <= 1'b0;
      end
      if (fin && state == BUSY_D) begin
        d_done <= 1'b1;
      end else if (!arb_stall) begin
        d_done <= 1'b0;
      end
    end
  end

  // Per-port read data, stable until the next completion of that port.
  // Stores leave d_rdata alone; an aborted access returns the error word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if (state == BUSY_I) begin
        if (ack_ok) begin
          i_rdata <= mem_rdata;
        end else if (timeout) begin
          i_rdata <= ERR_RDATA;
        end
      end
      if (state == BUSY_D) begin
        if (ack_ok) begin
          if (!mem_we) begin
            d_rdata <= mem_rdata;
          end
        end else if (timeout) begin
          d_rdata <= ERR_RDATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed requests, a simple bus responder, and
// scoreboard monitors for bus issues and for per-port results when the
// stall releases.
module tb_mem_arbiter;
  import mem_bus_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 255;
  localparam int CNT_W   = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              arb_stall;
  logic              bus_err;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .TIMEOUT (TIMEOUT), .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .arb_stall (arb_stall),
    .bus_err   (bus_err)
  );

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct packed {
    logic [31:0] i_rdata;
    logic [31:0] d_rdata;
  } res_exp_t;

  bus_exp_t exp_bus[$];
  res_exp_t exp_res[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- bus responder ----------------
  // ack_lat = 1-based cycle of a request in which the ack comes; 0 = never.
  int          ack_lat   = 0;
  logic        stray_ack = 1'b0;
  int          bus_cnt   = 0;
  logic [31:0] mem_img [logic [31:0]];

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (mem_req) begin
        bus_cnt++;
        if (ack_lat != 0 && bus_cnt == ack_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_img.exists(mem_addr) ? mem_img[mem_addr] : 32'h0;
          bus_cnt   = 0;
        end
      end else begin
        bus_cnt = 0;
      end
      if (stray_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  // ---------------- monitors ----------------
  logic     prev_req   = 1'b0;
  logic     prev_ack   = 1'b0;
  logic     prev_stall = 1'b0;
  logic     start;
  bus_exp_t held;
  bus_exp_t eb;
  res_exp_t er;

  always @(negedge clk) begin
    start = mem_req && (!prev_req || prev_ack);
    if (start) begin
      held = {mem_we, mem_be, mem_addr, mem_wdata};
      if (exp_bus.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL bus_issue: unexpected request addr=%0h, expected none", mem_addr);
      end else begin
        eb = exp_bus.pop_front();
        check("bus_addr", mem_addr, eb.addr);
        check("bus_we", mem_we, eb.we);
        check("bus_be", mem_be, eb.be);
        if (eb.we) check("bus_wdata", mem_wdata, eb.wdata);
      end
    end else if (mem_req && mem_ack) begin
      check("bus_hold", {mem_we, mem_be, mem_addr, mem_wdata}, held);
    end
    if (prev_stall && !arb_stall) begin
      if (exp_res.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL result: stall released with no result expected");
      end else begin
        er = exp_res.pop_front();
        check("i_rdata", i_rdata, er.i_rdata);
        check("d_rdata", d_rdata, er.d_rdata);
      end
    end
    prev_req   = mem_req;
    prev_ack   = mem_ack;
    prev_stall = arb_stall;
  end

  // ---------------- stimulus ----------------
  // Counts stall/req/err cycles from the request cycle until stall drops,
  // then withdraws the requests on the following cycle.
  task automatic run_txn(output int stall_c, output int req_c, output int err_c, output int err_at);
    int guard;
    guard   = 0;
    stall_c = 0;
    req_c   = 0;
    err_c   = 0;
    err_at  = 0;
    do begin
      @(negedge clk);
      if (arb_stall) stall_c++;
      if (mem_req) req_c++;
      if (bus_err) begin
        err_c++;
        err_at = stall_c;
      end
      guard++;
    end while (arb_stall && guard < 1000);
    if (guard >= 1000) begin
      n_tests++;
      n_fail++;
      $display("FAIL txn_bound: arb_stall still %0b after %0d cycles, expected 0", arb_stall, guard);
    end
    @(posedge clk);
    #1;
    i_req = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
  endtask

  int sc, rc, ec, ea;

  initial begin
    reset   = 1'b1;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_be    = 4'h0;
    d_addr  = '0;
    d_wdata = '0;
    mem_img[32'h0000_0100] = 32'h3C08_0001;
    mem_img[32'h0000_0104] = 32'h2402_0007;
    mem_img[32'h0000_2000] = 32'h8C09_0004;
    mem_img[32'h0000_3000] = 32'hFFFF_0000;
    mem_img[32'h0000_0108] = 32'h1111_2222;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_bus", {mem_we, mem_be, mem_addr, mem_wdata}, 69'h0);
    check("rst_rdata", {i_rdata, d_rdata}, 64'h0);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_stall", arb_stall, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single fetch, acked in the 3rd bus cycle.
    ack_lat = 3;
    i_req   = 1'b1;
    i_addr  = 32'h100;
    exp_bus.push_back(bus_exp_t'{we: 1'b0, be: BE_WORD, addr: 32'h100, wdata: 32'h0});
    exp_res.push_back(res_exp_t'{i_rdata: 32'h3C08_0001, d_rdata: 32'h0});
    run_txn(sc, rc, ec, ea);
    check("fetch_stall_cycles", sc, 4);
    check("fetch_req_cycles", rc, 3);
    check("fetch_no_err", ec, 0);
    @(posedge clk);
    #1;

    // Simultaneous load + fetch: D first, I back-to-back.
    ack_lat = 2;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_be    = 4'hF;
    d_addr  = 32'h2000;
    d_wdata = 32'h0;
    i_req   = 1'b1;
    i_addr  = 32'h104;
    exp_bus.push_back(bus_exp_t'{we: 1'b0, be: 4'hF, addr: 32'h2000, wdata: 32'h0});
    exp_bus.push_back(bus_exp_t'{we: 1'b0, be: BE_WORD, addr: 32'h104, wdata: 32'h0});
    exp_res.push_back(res_exp_t'{i_rdata: 32'h2402_0007, d_rdata: 32'h8C09_0004});
    run_txn(sc, rc, ec, ea);
    check("dual_stall_cycles", sc, 5);
    check("dual_req_cycles", rc, 4);
    @(posedge clk);
    #1;

    // Store: byte-enabled write, d_rdata must keep the previous load.
    ack_lat = 3;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_be    = 4'b0011;
    d_addr  = 32'h3000;
    d_wdata = 32'hDEAD_BEEF;
    exp_bus.push_back(bus_exp_t'{we: 1'b1, be: 4'b0011, addr: 32'h3000, wdata: 32'hDEAD_BEEF});
    exp_res.push_back(res_exp_t'{i_rdata: 32'h2402_0007, d_rdata: 32'h8C09_0004});
    run_txn(sc, rc, ec, ea);
    check("store_stall_cycles", sc, 4);
    check("store_req_cycles", rc, 3);
    @(posedge clk);
    #1;

    // Timeout: load never acked.
    ack_lat = 0;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_be    = 4'hF;
    d_addr  = 32'h4000;
    exp_bus.push_back(bus_exp_t'{we: 1'b0, be: 4'hF, addr: 32'h4000, wdata: 32'h0});
    exp_res.push_back(res_exp_t'{i_rdata: 32'h2402_0007, d_rdata: 32'h0});
    run_txn(sc, rc, ec, ea);
    check("to_req_cycles", rc, TIMEOUT);
    check("to_stall_cycles", sc, TIMEOUT + 1);
    check("to_err_pulses", ec, 1);
    check("to_err_last_stall", ea, TIMEOUT + 1);
    @(negedge clk);
    check("to_idle_req", mem_req, 1'b0);
    check("to_err_low", bus_err, 1'b0);
    @(posedge clk);
    #1;

    // Reset asserted asynchronously in the middle of a fetch.
    ack_lat = 0;
    i_req   = 1'b1;
    i_addr  = 32'h108;
    exp_bus.push_back(bus_exp_t'{we: 1'b0, be: BE_WORD, addr: 32'h108, wdata: 32'h0});
    repeat (3) @(negedge clk);
    check("rst_mid_busy", mem_req, 1'b1);
    @(posedge clk);
    #2;
    exp_res.push_back(res_exp_t'{i_rdata: 32'h0, d_rdata: 32'h0});
    reset = 1'b1;
    i_req = 1'b0;
    #1;
    check("arst_mem_req", mem_req, 1'b0);
    check("arst_mem_bus", {mem_we, mem_be, mem_addr, mem_wdata}, 69'h0);
    check("arst_rdata", {i_rdata, d_rdata}, 64'h0);
    check("arst_bus_err", bus_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Late / stray ack while idle with no requests.
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stray_req", mem_req, 1'b0);
      check("stray_stall", arb_stall, 1'b0);
    end
    check("stray_rdata", {i_rdata, d_rdata}, 64'h0);

    @(negedge clk);
    check("exp_bus_empty", exp_bus.size(), 0);
    check("exp_res_empty", exp_res.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
